// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-access stage and its MEM/WB register.
package mem_pkg;

    localparam int DEF_AW  = 32;
    localparam int DEF_DW  = 32;
    localparam int DEF_SCW = 16;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    // A bubble only kills the W-stage side effects; data fields are held.
    localparam wb_ctrl_t WB_CTRL_BUBBLE = '{pcsrc: 1'b0, regwrite: 1'b0, memtoreg: 1'b0};

endpackage

// File: rtl/mem_stage_wb_pipereg.sv
// MEM/WB pipeline register with bubble insertion and synchronous reset.
// MEM_ALIGN_CHECK_EN adds the misalign flag to the register.
module wb_pipereg
    import mem_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bubble,
    input  logic          ld_rdata,
    input  logic          pcsrc_in,
    input  logic          regwrite_in,
    input  logic          memtoreg_in,
    input  logic [3:0]    rd_in,
    input  logic [DW-1:0] alu_in,
    input  logic [DW-1:0] rdata_in,
`ifdef MEM_ALIGN_CHECK_EN
    input  logic          misalign_in,
    output logic          misalign_out,
`endif
    output logic          pcsrc_out,
    output logic          regwrite_out,
    output logic          memtoreg_out,
    output logic [3:0]    rd_out,
    output logic [DW-1:0] alu_out,
    output logic [DW-1:0] rdata_out
);

    wb_ctrl_t      ctrl_d, ctrl_q;
    logic [3:0]    rd_d, rd_q;
    logic [DW-1:0] alu_d, alu_q;
    logic [DW-1:0] rdata_d, rdata_q;

    always_comb begin
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        if (bubble) begin
            ctrl_d = WB_CTRL_BUBBLE;
        end else begin
            ctrl_d.pcsrc    = pcsrc_in;
            ctrl_d.regwrite = regwrite_in;
            ctrl_d.memtoreg = memtoreg_in;
            rd_d            = rd_in;
            alu_d           = alu_in;
            if (ld_rdata)
                rdata_d = rdata_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_d, misalign_q;

    assign misalign_d = misalign_in;

    always_ff @(posedge clk) begin
        if (reset)
            misalign_q <= 1'b0;
        else
            misalign_q <= misalign_d;
    end

    assign misalign_out = misalign_q;
`endif

    assign pcsrc_out    = ctrl_q.pcsrc;
    assign regwrite_out = ctrl_q.regwrite;
    assign memtoreg_out = ctrl_q.memtoreg;
    assign rd_out       = rd_q;
    assign alu_out      = alu_q;
    assign rdata_out    = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: valid/ready data bus, load/store stall FSM, stall counter, MEM/WB register.
// MEM_ALIGN_CHECK_EN enables misaligned-access detection and the MisalignW port.
module mem_stage
    import mem_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int SCW = DEF_SCW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           PCSrcM,
    input  logic           RegWriteM,
    input  logic           MemtoRegM,
    input  logic           MemWriteM,
    input  logic [3:0]     RdM,
    input  logic [DW-1:0]  ALUResultM,
    input  logic [DW-1:0]  WriteDataM,
    output logic           StallM,
    output logic           DReqValid,
    output logic           DReqWrite,
    output logic [AW-1:0]  DAddr,
    output logic [DW-1:0]  DWData,
    input  logic           DReqReady,
    input  logic           DRspValid,
    input  logic [DW-1:0]  DRData,
    output logic           PCSrcW,
    output logic           RegWriteW,
    output logic           MemtoRegW,
    output logic [3:0]     RdW,
    output logic [DW-1:0]  ReadDataW,
    output logic [DW-1:0]  ALUOutW,
`ifdef MEM_ALIGN_CHECK_EN
    output logic           MisalignW,
`endif
    output logic [SCW-1:0] StallCntW
);

    mem_state_e     state_d, state_q;
    logic [SCW-1:0] stall_cnt_d, stall_cnt_q;
    logic           mem_op, misalign, wb_bubble, wb_ld_rdata;

    assign mem_op = MemtoRegM | MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_op && (ALUResultM[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign DReqWrite = MemWriteM;
    assign DAddr     = ALUResultM[AW-1:0];
    assign DWData    = WriteDataM;

    always_comb begin
        state_d     = state_q;
        StallM      = 1'b0;
        DReqValid   = 1'b0;
        wb_bubble   = 1'b0;
        wb_ld_rdata = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (misalign) begin
                    wb_bubble = 1'b1;
                end else if (mem_op) begin
                    DReqValid = 1'b1;
                    // An accepted store retires here; loads must wait for data.
                    if (!(DReqReady && MemWriteM)) begin
                        StallM    = 1'b1;
                        wb_bubble = 1'b1;
                        if (DReqReady)
                            state_d = MS_WAIT;
                    end
                end
            end
            MS_WAIT: begin
                if (DRspValid) begin
                    wb_ld_rdata = 1'b1;
                    state_d     = MS_IDLE;
                end else begin
                    StallM    = 1'b1;
                    wb_bubble = 1'b1;
                end
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallM && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MS_IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCntW = stall_cnt_q;

    wb_pipereg #(.DW(DW)) u_wb (
        .clk          (clk),
        .reset        (reset),
        .bubble       (wb_bubble),
        .ld_rdata     (wb_ld_rdata),
        .pcsrc_in     (PCSrcM),
        .regwrite_in  (RegWriteM),
        .memtoreg_in  (MemtoRegM),
        .rd_in        (RdM),
        .alu_in       (ALUResultM),
        .rdata_in     (DRData),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_in  (misalign),
        .misalign_out (MisalignW),
`endif
        .pcsrc_out    (PCSrcW),
        .regwrite_out (RegWriteW),
        .memtoreg_out (MemtoRegW),
        .rd_out       (RdW),
        .alu_out      (ALUOutW),
        .rdata_out    (ReadDataW)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction stream.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [3:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, DReqValid, DReqWrite;
    logic [31:0] DAddr, DWData;
    logic        DReqReady, DRspValid;
    logic [31:0] DRData;
    logic        PCSrcW, RegWriteW, MemtoRegW;
    logic [3:0]  RdW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [15:0] StallCntW;
`ifdef MEM_ALIGN_CHECK_EN
    logic        MisalignW;
`endif

    int ntests = 0;
    int nfail  = 0;

    // Reference W-stage view: what writeback should see after each edge.
    logic        m_pcsrc, m_regw, m_m2r;
    logic [3:0]  m_rd;
    logic [31:0] m_alu, m_rdata;
    int          m_cnt;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrcM     (PCSrcM),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .DReqValid  (DReqValid),
        .DReqWrite  (DReqWrite),
        .DAddr      (DAddr),
        .DWData     (DWData),
        .DReqReady  (DReqReady),
        .DRspValid  (DRspValid),
        .DRData     (DRData),
        .PCSrcW     (PCSrcW),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .RdW        (RdW),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
`ifdef MEM_ALIGN_CHECK_EN
        .MisalignW  (MisalignW),
`endif
        .StallCntW  (StallCntW)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag);
        chk({tag, ".PCSrcW"},    32'(PCSrcW),    32'(m_pcsrc));
        chk({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(m_regw));
        chk({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'(m_m2r));
        chk({tag, ".RdW"},       32'(RdW),       32'(m_rd));
        chk({tag, ".ALUOutW"},   ALUOutW,        m_alu);
        chk({tag, ".ReadDataW"}, ReadDataW,      m_rdata);
        chk({tag, ".StallCntW"}, 32'(StallCntW), m_cnt);
    endtask

    task automatic model_reset();
        m_pcsrc = 0; m_regw = 0; m_m2r = 0;
        m_rd = 0; m_alu = 0; m_rdata = 0; m_cnt = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        DReqReady = 1'b0; DRspValid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk_w(tag);
`ifdef MEM_ALIGN_CHECK_EN
        chk({tag, ".MisalignW"}, 32'(MisalignW), 32'd0);
`endif
    endtask

    // One instruction in M. Bus holds ready low for r cycles; a load's response
    // comes d (>=1) cycles after acceptance. Returns cycles StallM was high.
    task automatic run_instr(input string tag, input logic pcsrc, input logic regw,
                             input logic m2r, input logic mw, input logic [3:0] rd,
                             input logic [31:0] alu, input logic [31:0] wdata,
                             input int r, input int d, input logic [31:0] rdata,
                             input logic force_rsp, output int stalls);
        logic mem, load;
        int   total;
        mem   = m2r | mw;
        load  = m2r & ~mw;
        total = !mem ? 1 : (load ? r + d + 1 : r + 1);
        stalls = total - 1;
        PCSrcM = pcsrc; RegWriteM = regw; MemtoRegM = m2r; MemWriteM = mw;
        RdM = rd; ALUResultM = alu; WriteDataM = wdata;
        for (int k = 0; k < total; k++) begin
            DReqReady = mem && !(load && k > r) ? (k == r) : 1'($urandom);
            if (load && k > r)      DRspValid = (k == r + d);
            else if (mem && k == r) DRspValid = 1'b0;
            else                    DRspValid = 1'($urandom) | force_rsp;
            DRData = (load && k == r + d) ? rdata : $urandom;
            @(negedge clk);
            chk({tag, ".StallM"},    32'(StallM),    32'(k < total - 1));
            chk({tag, ".DReqValid"}, 32'(DReqValid), 32'(mem && k <= r));
            if (mem && k <= r) begin
                chk({tag, ".DReqWrite"}, 32'(DReqWrite), 32'(mw));
                chk({tag, ".DAddr"},     DAddr,  alu);
                chk({tag, ".DWData"},    DWData, wdata);
            end
            @(posedge clk); #1;
            if (k < total - 1) begin
                m_pcsrc = 0; m_regw = 0; m_m2r = 0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_pcsrc = pcsrc; m_regw = regw; m_m2r = m2r;
                m_rd = rd; m_alu = alu;
                if (load) m_rdata = rdata;
            end
            chk_w(tag);
        end
    endtask

    initial begin
        int st;
        reset = 1'b1;
        PCSrcM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
        RdM = 0; ALUResultM = 0; WriteDataM = 0;
        DReqReady = 0; DRspValid = 0; DRData = 0;
        @(posedge clk); #1;
        do_reset("reset");

        run_instr("add", 0, 1, 0, 0, 4'd3, 32'h10, 32'h0, 0, 0, 32'h0, 0, st);
        run_instr("store", 0, 0, 0, 1, 4'd5, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 0, st);
        chk("store.stalls", 32'(StallCntW), 32'd0);

        do_reset("reset2");
        run_instr("load", 0, 1, 1, 0, 4'd7, 32'h200, 32'h0, 2, 3, 32'h12345678, 0, st);
        chk("load.StallCntW", 32'(StallCntW), 32'd5);
        chk("load.ReadDataW", ReadDataW, 32'h12345678);

        run_instr("pcsrc_load", 1, 1, 1, 0, 4'd2, 32'h300, 32'h0, 1, 2, 32'hCAFEF00D, 0, st);
        run_instr("pcsrc_next", 0, 0, 0, 0, 4'd1, 32'h44, 32'h0, 0, 0, 32'h0, 0, st);

        // Reset while a load is outstanding; a late response must be dropped.
        PCSrcM = 0; RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0;
        RdM = 4'd9; ALUResultM = 32'h400;
        DReqReady = 1; DRspValid = 0;
        @(posedge clk); #1;
        do_reset("reset_wait");
        run_instr("post_rst1", 0, 1, 0, 0, 4'd4, 32'h55, 32'h0, 0, 0, 32'h0, 0, st);
        run_instr("post_rst2", 0, 1, 0, 0, 4'd6, 32'h66, 32'h0, 0, 0, 32'h0, 1, st);

`ifdef MEM_ALIGN_CHECK_EN
        PCSrcM = 0; RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0;
        RdM = 4'd8; ALUResultM = 32'h202; DReqReady = 1; DRspValid = 0;
        @(negedge clk);
        chk("mis.DReqValid", 32'(DReqValid), 32'd0);
        chk("mis.StallM",    32'(StallM),    32'd0);
        @(posedge clk); #1;
        chk("mis.MisalignW", 32'(MisalignW), 32'd1);
        chk("mis.RegWriteW", 32'(RegWriteW), 32'd0);
        m_pcsrc = 0; m_regw = 0; m_m2r = 0;
        run_instr("mis_next", 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0, 0, 32'h0, 0, st);
        chk("mis.clear", 32'(MisalignW), 32'd0);
`endif

        for (int i = 0; i < 200; i++) begin
            int op;
            logic m2r, mw;
            logic [31:0] alu;
            op  = $urandom_range(0, 3);
            m2r = (op == 1) || (op == 3);
            mw  = (op == 2) || (op == 3);
            alu = $urandom;
            if (m2r | mw) alu[1:0] = 2'b00;
            run_instr("rand", 1'($urandom), 1'($urandom), m2r, mw, 4'($urandom), alu,
                      $urandom, $urandom_range(0, 3), $urandom_range(1, 4), $urandom, 0, st);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
